// File: rtl/score_star_renderer_if.sv
// Pixel-pipeline bundle for the score-star overlay: frame/score/coordinate
// inputs towards the renderer and the registered colour outputs back.
interface score_star_renderer_if #(
  parameter int PTS_W = 4
);
  logic             finish_frame;
  logic [1:0]       level_state;
  logic [PTS_W-1:0] pts1;
  logic [PTS_W-1:0] pts2;
  logic [9:0]       row;
  logic [9:0]       col;
  logic [7:0]       red;
  logic [7:0]       green;
  logic [7:0]       blue;
  logic             is_star;
  logic             spawn_busy;

  modport master (
    output finish_frame, level_state, pts1, pts2, row, col,
    input  red, green, blue, is_star, spawn_busy
  );

  modport slave (
    input  finish_frame, level_state, pts1, pts2, row, col,
    output red, green, blue, is_star, spawn_busy
  );
endinterface

// File: rtl/score_star_renderer.sv
// Score-star overlay: NUM_STARS star sprites per player in two staggered rows,
// one lit star per point, twinkle phase from a frame counter, and a three-step
// grow-in animation on the newest star whenever a player's count increases.
module score_star_renderer #(
  parameter int NUM_STARS = 9,
  parameter int PTS_W     = 4,
  parameter int X0        = 80,
  parameter int X_STEP    = 80,
  parameter int Y1A       = 100,
  parameter int Y1B       = 200,
  parameter int Y2A       = 300,
  parameter int Y2B       = 400,
  parameter int TW_W      = 8,
  parameter int SPAWN_FR  = 16
) (
  input logic                   clock,
  input logic                   reset,
  score_star_renderer_if.slave  bus
);

  localparam int FW = (SPAWN_FR > 1) ? $clog2(SPAWN_FR) : 1;

  typedef enum logic [1:0] {S_IDLE, S_G0, S_G1, S_G2} spawn_t;

  spawn_t          st_q   [2];
  spawn_t          st_d   [2];
  logic [FW-1:0]   fc_q   [2];
  logic [FW-1:0]   fc_d   [2];
  logic [3:0]      cnt_q  [2];
  logic [3:0]      cnt_d  [2];
  logic [3:0]      tgt_q  [2];
  logic [3:0]      tgt_d  [2];
  logic [3:0]      new_cnt[2];
  logic [TW_W-1:0] tw_q;

  logic [2:0]      hit [2];
  logic [1:0]      base_ph;
  logic [1:0]      ph;
  logic            lit;
  int              sx, sy, dx, dy;
  logic            ctr, r1, r2, idot, odot;
  logic            sel_hit;
  logic [23:0]     sel_rgb;

  function automatic logic [3:0] clamp_cnt(input logic [PTS_W-1:0] p);
    if (int'(p) > NUM_STARS) return 4'(NUM_STARS);
    return 4'(p);
  endfunction

  function automatic logic in_rng(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic [23:0] palette(input logic [1:0] lvl, input logic pl,
                                          input logic [1:0] cls);
    logic [23:0] c;
    c = '0;
    case ({lvl, pl, cls})
      5'b00_0_00: c = 24'hdaadf0;  5'b00_0_01: c = 24'hb06dcf;  5'b00_0_10: c = 24'h7344a6;
      5'b00_1_00: c = 24'he8d590;  5'b00_1_01: c = 24'he3b468;  5'b00_1_10: c = 24'hed8f4c;
      5'b01_0_00: c = 24'hb9a3e6;  5'b01_0_01: c = 24'h7767b8;  5'b01_0_10: c = 24'h57499c;
      5'b01_1_00: c = 24'hd9cd8b;  5'b01_1_01: c = 24'hc9aa61;  5'b01_1_10: c = 24'hc49847;
      5'b10_0_00: c = 24'hada3e6;  5'b10_0_01: c = 24'h6a68b3;  5'b10_0_10: c = 24'h514a91;
      5'b10_1_00: c = 24'hba9970;  5'b10_1_01: c = 24'ha67e67;  5'b10_1_10: c = 24'h7a5057;
      5'b11_0_00: c = 24'he0d0e8;  5'b11_0_01: c = 24'ha37cb3;  5'b11_0_10: c = 24'h694187;
      5'b11_1_00: c = 24'hd0d4e8;  5'b11_1_01: c = 24'h7c86b3;  5'b11_1_10: c = 24'h45507d;
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Per-player score latch and grow-in FSM, advanced only on frame boundaries.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      st_d[p]    = st_q[p];
      fc_d[p]    = fc_q[p];
      cnt_d[p]   = cnt_q[p];
      tgt_d[p]   = tgt_q[p];
      new_cnt[p] = clamp_cnt((p == 0) ? bus.pts1 : bus.pts2);
      if (bus.finish_frame) begin
        cnt_d[p] = new_cnt[p];
        if (new_cnt[p] > cnt_q[p]) begin
          st_d[p]  = S_G0;
          fc_d[p]  = '0;
          tgt_d[p] = (p == 0) ? (new_cnt[p] - 4'd1) : (4'(NUM_STARS) - new_cnt[p]);
        end else if (new_cnt[p] < cnt_q[p]) begin
          st_d[p] = S_IDLE;
          fc_d[p] = '0;
        end else if (st_q[p] != S_IDLE) begin
          if (fc_q[p] == FW'(SPAWN_FR - 1)) begin
            fc_d[p] = '0;
            unique case (st_q[p])
              S_G0:    st_d[p] = S_G1;
              S_G1:    st_d[p] = S_G2;
              default: st_d[p] = S_IDLE;
            endcase
          end else begin
            fc_d[p] = fc_q[p] + FW'(1);
          end
        end
      end
    end
  end

  // State registers: spawn FSMs, latched counts, twinkle counter, busy flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned p = 0; p < 2; p++) begin
        st_q[p]  <= S_IDLE;
        fc_q[p]  <= '0;
        cnt_q[p] <= '0;
        tgt_q[p] <= '0;
      end
      tw_q           <= '0;
      bus.spawn_busy <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        st_q[p]  <= st_d[p];
        fc_q[p]  <= fc_d[p];
        cnt_q[p] <= cnt_d[p];
        tgt_q[p] <= tgt_d[p];
      end
      if (bus.finish_frame) tw_q <= tw_q + TW_W'(1);
      bus.spawn_busy <= (st_d[0] != S_IDLE) || (st_d[1] != S_IDLE);
    end
  end

  assign base_ph = tw_q[TW_W-1 -: 2];

  // Star geometry: accumulate centre/ring1/ring2 class hits over every lit star.
  // Offsets are taken in full int width so stars near the left/top edge never wrap.
  always_comb begin
    hit[0] = '0;
    hit[1] = '0;
    ph = '0; lit = 1'b0;
    sx = 0; sy = 0; dx = 0; dy = 0;
    ctr = 1'b0; r1 = 1'b0; r2 = 1'b0; idot = 1'b0; odot = 1'b0;
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned i = 0; i < NUM_STARS; i++) begin
        lit = (p == 0) ? (i < 32'(cnt_q[0])) : (i >= 32'(NUM_STARS) - 32'(cnt_q[1]));
        if (st_q[p] != S_IDLE && 32'(tgt_q[p]) == i)
          ph = (st_q[p] == S_G0) ? 2'd0 : ((st_q[p] == S_G1) ? 2'd1 : 2'd2);
        else
          ph = base_ph;
        sx = X0 + int'(i) * X_STEP;
        if (i % 2 == 0) sy = (p == 0) ? Y1A : Y2A;
        else            sy = (p == 0) ? Y1B : Y2B;
        dx = int'(bus.col) - sx;
        dy = int'(bus.row) - sy;
        ctr  = in_rng(dx, 0, 4) && in_rng(dy, 0, 4);
        r1   = ((in_rng(dx, 5, 9) || in_rng(dx, -5, -1)) && in_rng(dy, 0, 4)) ||
               ((in_rng(dy, 5, 9) || in_rng(dy, -5, -1)) && in_rng(dx, 0, 4));
        r2   = ((in_rng(dx, 10, 14) || in_rng(dx, -10, -6)) && in_rng(dy, 0, 4)) ||
               ((in_rng(dy, 10, 14) || in_rng(dy, -10, -6)) && in_rng(dx, 0, 4));
        idot = (dx == 9 || dx == -5) && (dy == 9 || dy == -5);
        odot = (dx == 14 || dx == -10) && (dy == 14 || dy == -10);
        if (lit) begin
          hit[p][0] = hit[p][0] | ctr | ((ph == 2'd2) & odot);
          hit[p][1] = hit[p][1] | ((ph != 2'd0) & r1) | (((ph == 2'd1) || (ph == 2'd2)) & idot);
          hit[p][2] = hit[p][2] | ((ph == 2'd2) & r2);
        end
      end
    end
  end

  // Fixed priority across players and colour classes, palette by level.
  always_comb begin
    sel_hit = 1'b1;
    sel_rgb = '0;
    if      (hit[0][0]) sel_rgb = palette(bus.level_state, 1'b0, 2'd0);
    else if (hit[0][1]) sel_rgb = palette(bus.level_state, 1'b0, 2'd1);
    else if (hit[0][2]) sel_rgb = palette(bus.level_state, 1'b0, 2'd2);
    else if (hit[1][0]) sel_rgb = palette(bus.level_state, 1'b1, 2'd0);
    else if (hit[1][1]) sel_rgb = palette(bus.level_state, 1'b1, 2'd1);
    else if (hit[1][2]) sel_rgb = palette(bus.level_state, 1'b1, 2'd2);
    else                sel_hit = 1'b0;
  end

  // Registered pixel output, one clock behind row/col.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.red     <= '0;
      bus.green   <= '0;
      bus.blue    <= '0;
      bus.is_star <= 1'b0;
    end else begin
      {bus.red, bus.green, bus.blue} <= sel_rgb;
      bus.is_star                    <= sel_hit;
    end
  end

endmodule

// File: tb/tb_score_star_renderer.sv
// Randomised scoreboard bench for score_star_renderer with a star-centred
// reference model (distances from each star's middle pixel).
module tb_score_star_renderer;

  localparam int N   = 9;
  localparam int PW  = 4;
  localparam int X0  = 5;
  localparam int XS  = 80;
  localparam int Y1A = 100;
  localparam int Y1B = 200;
  localparam int Y2A = 300;
  localparam int Y2B = 200;
  localparam int TW  = 6;
  localparam int SF  = 3;

  localparam logic [23:0] PAL [4][2][3] = '{
    '{'{24'hdaadf0, 24'hb06dcf, 24'h7344a6}, '{24'he8d590, 24'he3b468, 24'hed8f4c}},
    '{'{24'hb9a3e6, 24'h7767b8, 24'h57499c}, '{24'hd9cd8b, 24'hc9aa61, 24'hc49847}},
    '{'{24'hada3e6, 24'h6a68b3, 24'h514a91}, '{24'hba9970, 24'ha67e67, 24'h7a5057}},
    '{'{24'he0d0e8, 24'ha37cb3, 24'h694187}, '{24'hd0d4e8, 24'h7c86b3, 24'h45507d}}
  };

  logic clock = 1'b0;
  logic reset;

  score_star_renderer_if #(.PTS_W(PW)) bus ();

  score_star_renderer #(
    .NUM_STARS(N), .PTS_W(PW), .X0(X0), .X_STEP(XS),
    .Y1A(Y1A), .Y1B(Y1B), .Y2A(Y2A), .Y2B(Y2B),
    .TW_W(TW), .SPAWN_FR(SF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [23:0] rgb;
    logic        star;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // reference model state
  int m_tw;
  int m_cnt  [2];
  bit m_anim [2];
  int m_age  [2];
  int cur_p1, cur_p2;

  function automatic int sat(int p);
    return (p > N) ? N : p;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // class of a pixel at offset (dx,dy) from a star's top-left: 1 bright, 2 mid, 3 dim, 0 none
  function automatic int star_class(int dx, int dy, int ph);
    int ax, ay;
    ax = iabs(dx - 2);
    ay = iabs(dy - 2);
    if (ax <= 2 && ay <= 2) return 1;
    if (ph == 2 && ax == 12 && ay == 12) return 1;
    if (ph != 0 && ((ax <= 2 && ay >= 3 && ay <= 7) || (ay <= 2 && ax >= 3 && ax <= 7))) return 2;
    if ((ph == 1 || ph == 2) && ax == 7 && ay == 7) return 2;
    if (ph == 2 && ((ax <= 2 && ay >= 8 && ay <= 12) || (ay <= 2 && ax >= 8 && ax <= 12))) return 3;
    return 0;
  endfunction

  function automatic void ref_pixel(input int lvl, input int r, input int c,
                                    output logic [23:0] rgb, output logic hit);
    int best, ph, x, y, cls, newest;
    bit is_lit;
    best = 99;
    for (int pl = 0; pl < 2; pl++) begin
      newest = (pl == 0) ? m_cnt[0] - 1 : N - m_cnt[1];
      for (int i = 0; i < N; i++) begin
        is_lit = (pl == 0) ? (i < m_cnt[0]) : (i >= N - m_cnt[1]);
        if (!is_lit) continue;
        ph = (m_anim[pl] && i == newest) ? m_age[pl] / SF : m_tw / (1 << (TW - 2));
        x = X0 + i * XS;
        if (pl == 0) y = (i % 2 == 0) ? Y1A : Y1B;
        else         y = (i % 2 == 0) ? Y2A : Y2B;
        cls = star_class(c - x, r - y, ph);
        if (cls != 0 && pl * 3 + cls < best) best = pl * 3 + cls;
      end
    end
    if (best == 99) begin
      rgb = '0;
      hit = 1'b0;
    end else begin
      rgb = PAL[lvl][(best - 1) / 3][(best - 1) % 3];
      hit = 1'b1;
    end
  endfunction

  task automatic model_update(input bit rst, input bit ff, input int p1, input int p2);
    int nc;
    if (rst) begin
      m_tw = 0;
      for (int pl = 0; pl < 2; pl++) begin
        m_cnt[pl] = 0; m_anim[pl] = 0; m_age[pl] = 0;
      end
    end else if (ff) begin
      m_tw = (m_tw + 1) % (1 << TW);
      for (int pl = 0; pl < 2; pl++) begin
        nc = sat((pl == 0) ? p1 : p2);
        if (nc > m_cnt[pl]) begin
          m_anim[pl] = 1; m_age[pl] = 0;
        end else if (nc < m_cnt[pl]) begin
          m_anim[pl] = 0;
        end else if (m_anim[pl]) begin
          m_age[pl]++;
          if (m_age[pl] >= 3 * SF) m_anim[pl] = 0;
        end
        m_cnt[pl] = nc;
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit ff, input int lvl,
                       input int p1, input int p2, input int r, input int c);
    exp_t e;
    @(negedge clock);
    reset            = rst;
    bus.finish_frame = ff;
    bus.level_state  = 2'(lvl);
    bus.pts1         = PW'(p1);
    bus.pts2         = PW'(p2);
    bus.row          = 10'(r);
    bus.col          = 10'(c);
    if (rst) begin
      e.rgb  = '0;
      e.star = 1'b0;
    end else begin
      ref_pixel(lvl, r, c, e.rgb, e.star);
    end
    model_update(rst, ff, p1, p2);
    e.busy = m_anim[0] | m_anim[1];
    sb.push_back(e);
  endtask

  task automatic pick(output int r, output int c);
    int i, pl, x, y;
    if ($urandom % 4 == 0) begin
      r = int'($urandom % 480);
      c = int'($urandom % 640);
    end else begin
      i  = int'($urandom % N);
      pl = int'($urandom % 2);
      x  = X0 + i * XS;
      if (pl == 0) y = (i % 2 == 0) ? Y1A : Y1B;
      else         y = (i % 2 == 0) ? Y2A : Y2B;
      c = x + int'($urandom_range(0, 30)) - 13;
      r = y + int'($urandom_range(0, 30)) - 13;
      if (c < 0) c = 0;
      if (r < 0) r = 0;
    end
  endtask

  task automatic rand_pixel();
    int r, c;
    pick(r, c);
    cycle(1'b0, 1'b0, int'($urandom % 4), cur_p1, cur_p2, r, c);
  endtask

  task automatic frame(input int pixels);
    int r, c;
    pick(r, c);
    cycle(1'b0, 1'b1, int'($urandom % 4), cur_p1, cur_p2, r, c);
    repeat (pixels) rand_pixel();
  endtask

  function automatic int bump(int v);
    case ($urandom % 8)
      0, 1:    return (v < 15) ? v + 1 : v;
      2:       return (v > 0) ? v - 1 : v;
      3:       return int'($urandom % 16);
      default: return v;
    endcase
  endfunction

  // monitor: the DUT presents a pixel every cycle, one clock after its inputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        vectors++;
        if ({bus.red, bus.green, bus.blue} !== e.rgb || bus.is_star !== e.star ||
            bus.spawn_busy !== e.busy) begin
          miscompares++;
          $display("FAIL pixel #%0d: got rgb=%06h is_star=%0b spawn_busy=%0b, expected rgb=%06h is_star=%0b spawn_busy=%0b",
                   vectors, {bus.red, bus.green, bus.blue}, bus.is_star, bus.spawn_busy,
                   e.rgb, e.star, e.busy);
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    cur_p1 = 0;
    cur_p2 = 0;
    m_tw   = 0;
    for (int pl = 0; pl < 2; pl++) begin
      m_cnt[pl] = 0; m_anim[pl] = 0; m_age[pl] = 0;
    end

    // reset, then zero scores: nothing may light up
    repeat (3) cycle(1'b1, 1'b0, 0, 0, 0, Y1A, X0);
    frame(60);

    // three points for player 1: star 0 centre lit, star 3 dark, near-edge columns do not wrap
    cur_p1 = 3;
    frame(0);
    cycle(1'b0, 1'b0, 0, cur_p1, cur_p2, Y1A, X0);
    cycle(1'b0, 1'b0, 0, cur_p1, cur_p2, Y1A, X0 + 3 * XS);
    for (int k = 1019; k < 1024; k++) cycle(1'b0, 1'b0, 1, cur_p1, cur_p2, Y1A + 2, k);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1, cur_p1, cur_p2, Y1A + 2, k);

    // player 2 saturates; repeated saturated score must not restart an animation
    cur_p2 = 15;
    frame(4);
    cycle(1'b0, 1'b0, 3, cur_p1, cur_p2, Y2B, X0 + XS);
    cycle(1'b0, 1'b0, 3, cur_p1, cur_p2, Y2A, X0 + 2 * XS);
    repeat (12) frame(6);

    // long randomised run of score changes, twinkle wraps and animations
    for (int f = 0; f < 250; f++) begin
      cur_p1 = bump(cur_p1);
      cur_p2 = bump(cur_p2);
      frame(14);
    end

    // reset lands in the middle grow-in step together with a frame pulse
    cur_p1 = 0;
    frame(2);
    cur_p1 = 4;
    frame(2);
    repeat (SF + 1) frame(2);
    cycle(1'b1, 1'b1, 2, cur_p1, cur_p2, Y1A, X0 + 3 * XS);
    repeat (30) rand_pixel();
    frame(20);

    repeat (3) @(negedge clock);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected pixels never checked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
